vreg_file_responder: RTL and testbench

//  Responder side of the vector-register request interface driven by each core pipeline.
//  Two request groups are served on every cycle:
//   - lane/execution read requests (reg_req) through one read port;
//   - write-buffer write requests (wb_reg_req) through one write port.

---
 rtl/vreg_file_responder_pkg.sv | 26 ++
 rtl/vreg_file_responder_rr_arbiter.sv | 48 ++++
 rtl/vreg_file_responder.sv | 141 ++++++++++++++
 tb/tb_vreg_file_responder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vreg_file_responder_pkg.sv
// Shared definitions for the vector-register responder: sizes, request format, element-index helper.
package vreg_file_responder_pkg;

  localparam int NUM_OF_LANES      = 4;
  localparam int NUM_OF_WB         = 2;
  localparam int NUM_OF_VECTOR_REG = 32;
  localparam int VECTOR_LEN        = 64;
  localparam int VECTOR_REG_WIDTH  = 64;

  localparam int REG_ID_W = $clog2(NUM_OF_VECTOR_REG);
  localparam int ELEM_W   = $clog2(VECTOR_LEN);
  localparam int ADDR_W   = 16;

  typedef struct packed {
    logic                        vld;
    logic [REG_ID_W-1:0]         reg_id;
    logic [ADDR_W-1:0]           addr;
    logic [VECTOR_REG_WIDTH-1:0] data;
  } cntrl_req_t;

  // Element index is the low address bits; anything above selects nothing.
  function automatic logic [ELEM_W-1:0] elem_idx(input logic [ADDR_W-1:0] addr);
    return addr[ELEM_W-1:0];
  endfunction

endpackage

// File: rtl/vreg_file_responder_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer, pointer moves past each winner.
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] next_ptr;
  logic          found;
  int            idx;

  always_comb begin
    gnt      = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N) begin
        idx = idx - N;
      end else begin
        idx = idx;
      end
      if (advance && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        next_ptr = (idx == N - 1) ? '0 : PW'(idx + 1);
      end else begin
        found = found;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else begin
      ptr <= next_ptr;
    end
  end

endmodule

// File: rtl/vreg_file_responder.sv
// Vector-register responder: one arbitrated read port, one arbitrated write port, row-by-row clear after reset.
// Optional macro VREG_WR_BYPASS_EN makes a same-cycle colliding read return the data being written.
module vreg_file_responder
  import vreg_file_responder_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  cntrl_req_t                  reg_req          [NUM_OF_LANES],
  output logic [NUM_OF_LANES-1:0]     reg_req_grant,
  output logic [NUM_OF_LANES-1:0]     reg_rsp_vld,
  output logic [VECTOR_REG_WIDTH-1:0] reg_rsp_data     [NUM_OF_LANES],
  input  cntrl_req_t                  wb_reg_req       [NUM_OF_WB],
  output logic [NUM_OF_WB-1:0]        wb_reg_req_grant,
  output logic [NUM_OF_WB-1:0]        wb_reg_rsp_vld,
  output logic [VECTOR_REG_WIDTH-1:0] wb_reg_rsp_data  [NUM_OF_WB],
  output logic                        init_done
);

  localparam int LANE_W = $clog2(NUM_OF_LANES);
  localparam int WB_W   = (NUM_OF_WB > 1) ? $clog2(NUM_OF_WB) : 1;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t                      state, next_state;
  logic [REG_ID_W-1:0]         init_row;
  logic                        init_last;
  logic                        serve;
  logic [NUM_OF_LANES-1:0]     rd_vld;
  logic [NUM_OF_WB-1:0]        wr_vld;
  logic [LANE_W-1:0]           rd_sel, rd_ptr;
  logic [WB_W-1:0]             wr_sel, wr_ptr;
  logic                        rd_any, wr_any;
  cntrl_req_t                  rd_req, wr_req;
  logic [ELEM_W-1:0]           rd_elem, wr_elem;
  logic [VECTOR_REG_WIDTH-1:0] rd_word;
  logic [VECTOR_REG_WIDTH-1:0] mem [NUM_OF_VECTOR_REG][VECTOR_LEN];

  always_comb begin
    next_state = state;
    init_last  = 1'b0;
    case (state)
      INIT: begin
        if (init_row == REG_ID_W'(NUM_OF_VECTOR_REG - 1)) begin
          next_state = RUN;
          init_last  = 1'b1;
        end else begin
          next_state = INIT;
        end
      end
      RUN:     next_state = RUN;
      default: next_state = INIT;
    endcase
  end

  // Requests are only served in RUN; a pending reset already counts as leaving RUN.
  assign serve = (state == RUN) && !reset;

  always_comb begin
    rd_vld = '0;
    wr_vld = '0;
    for (int i = 0; i < NUM_OF_LANES; i++) rd_vld[i] = reg_req[i].vld;
    for (int j = 0; j < NUM_OF_WB; j++)    wr_vld[j] = wb_reg_req[j].vld;
  end

  rr_arbiter #(.N(NUM_OF_LANES)) u_rd_arb (
    .clk(clk), .reset(reset), .req(rd_vld), .advance(serve), .gnt(reg_req_grant), .ptr(rd_ptr)
  );

  rr_arbiter #(.N(NUM_OF_WB)) u_wr_arb (
    .clk(clk), .reset(reset), .req(wr_vld), .advance(serve), .gnt(wb_reg_req_grant), .ptr(wr_ptr)
  );

  always_comb begin
    rd_sel = '0;
    rd_any = 1'b0;
    wr_sel = '0;
    wr_any = 1'b0;
    for (int i = 0; i < NUM_OF_LANES; i++) begin
      if (reg_req_grant[i]) begin
        rd_sel = LANE_W'(i);
        rd_any = 1'b1;
      end else begin
        rd_any = rd_any;
      end
    end
    for (int j = 0; j < NUM_OF_WB; j++) begin
      if (wb_reg_req_grant[j]) begin
        wr_sel = WB_W'(j);
        wr_any = 1'b1;
      end else begin
        wr_any = wr_any;
      end
    end
  end

  assign rd_req  = reg_req[rd_sel];
  assign wr_req  = wb_reg_req[wr_sel];
  assign rd_elem = elem_idx(rd_req.addr);
  assign wr_elem = elem_idx(wr_req.addr);

  always_comb begin
    rd_word = mem[rd_req.reg_id][rd_elem];
`ifdef VREG_WR_BYPASS_EN
    if (wr_any && (wr_req.reg_id == rd_req.reg_id) && (wr_elem == rd_elem)) begin
      rd_word = wr_req.data;
    end else begin
      rd_word = mem[rd_req.reg_id][rd_elem];
    end
`endif
  end

  // Storage: one full row cleared per INIT cycle, otherwise the granted write lands here.
  always_ff @(posedge clk) begin
    if ((state == INIT) && !reset) begin
      for (int e = 0; e < VECTOR_LEN; e++) mem[init_row][e] <= '0;
    end else if (wr_any) begin
      mem[wr_req.reg_id][wr_elem] <= wr_req.data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= INIT;
      init_row       <= '0;
      init_done      <= 1'b0;
      reg_rsp_vld    <= '0;
      wb_reg_rsp_vld <= '0;
      for (int i = 0; i < NUM_OF_LANES; i++) reg_rsp_data[i] <= '0;
      for (int j = 0; j < NUM_OF_WB; j++)    wb_reg_rsp_data[j] <= '0;
    end else begin
      state          <= next_state;
      init_row       <= (state == INIT) ? init_row + REG_ID_W'(1) : init_row;
      init_done      <= init_done | init_last;
      reg_rsp_vld    <= reg_req_grant;
      wb_reg_rsp_vld <= wb_reg_req_grant;
      if (rd_any) reg_rsp_data[rd_sel] <= rd_word;
      if (wr_any) wb_reg_rsp_data[wr_sel] <= wr_req.data;
    end
  end

endmodule

// File: tb/tb_vreg_file_responder.sv
// Directed self-checking bench for vreg_file_responder: init sweep, read/write, arbitration, collision, reset.
module tb_vreg_file_responder;
  import vreg_file_responder_pkg::*;

  logic                        clk = 1'b0;
  logic                        reset;
  cntrl_req_t                  reg_req          [NUM_OF_LANES];
  logic [NUM_OF_LANES-1:0]     reg_req_grant, reg_rsp_vld;
  logic [VECTOR_REG_WIDTH-1:0] reg_rsp_data     [NUM_OF_LANES];
  cntrl_req_t                  wb_reg_req       [NUM_OF_WB];
  logic [NUM_OF_WB-1:0]        wb_reg_req_grant, wb_reg_rsp_vld;
  logic [VECTOR_REG_WIDTH-1:0] wb_reg_rsp_data  [NUM_OF_WB];
  logic                        init_done;

  int total = 0;
  int bad   = 0;

`ifdef VREG_WR_BYPASS_EN
  localparam logic [63:0] COLLIDE_EXP = 64'h1;
`else
  localparam logic [63:0] COLLIDE_EXP = 64'h0;
`endif

  vreg_file_responder dut (
    .clk(clk), .reset(reset),
    .reg_req(reg_req), .reg_req_grant(reg_req_grant), .reg_rsp_vld(reg_rsp_vld), .reg_rsp_data(reg_rsp_data),
    .wb_reg_req(wb_reg_req), .wb_reg_req_grant(wb_reg_req_grant), .wb_reg_rsp_vld(wb_reg_rsp_vld),
    .wb_reg_rsp_data(wb_reg_rsp_data), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NUM_OF_LANES; i++) reg_req[i] = '0;
    for (int j = 0; j < NUM_OF_WB; j++)    wb_reg_req[j] = '0;
  endtask

  // Called with reset just released; counts edges until init_done and notes any grant seen meanwhile.
  task automatic wait_init(output int cyc, output int seen);
    cyc  = 0;
    seen = 0;
    while (init_done !== 1'b1 && cyc < 100) begin
      if (reg_req_grant !== '0 || wb_reg_req_grant !== '0) seen++;
      step();
      cyc++;
    end
  endtask

  task automatic do_reset_and_check(input string tag);
    int cyc, seen;
    reset = 1'b1;
    step();
    reset = 1'b0;
    wait_init(cyc, seen);
    total++;
    if (cyc !== 32) begin bad++; $display("FAIL %s_init_cycles actual=%0d required=32", tag, cyc); end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL %s_grant_in_init actual=%0d required=0", tag, seen); end
  endtask

  task automatic test_reset();
    clear_reqs();
    reset = 1'b1;
    repeat (2) step();
    total++;
    if (init_done !== 1'b0 || reg_rsp_vld !== 4'b0000 || wb_reg_rsp_vld !== 2'b00) begin
      bad++; $display("FAIL reset_ctrl actual=%b/%b/%b required=0/0000/00", init_done, reg_rsp_vld, wb_reg_rsp_vld);
    end
    total++;
    if (reg_rsp_data[0] !== 64'h0 || wb_reg_rsp_data[1] !== 64'h0) begin
      bad++; $display("FAIL reset_data actual=%h/%h required=0/0", reg_rsp_data[0], wb_reg_rsp_data[1]);
    end
    reg_req[0] = '{vld: 1'b1, reg_id: 5'd10, addr: 16'hFF54, data: 64'h0};
    reset = 1'b0;
    begin
      int cyc, seen;
      wait_init(cyc, seen);
      total++;
      if (cyc !== 32) begin bad++; $display("FAIL init_cycles actual=%0d required=32", cyc); end
      total++;
      if (seen !== 0) begin bad++; $display("FAIL grant_in_init actual=%0d required=0", seen); end
    end
    total++;
    if (reg_req_grant !== 4'b0001) begin bad++; $display("FAIL first_grant actual=%b required=0001", reg_req_grant); end
    step();
    reg_req[0] = '0;
    total++;
    if (reg_rsp_vld !== 4'b0001 || reg_rsp_data[0] !== 64'h0) begin
      bad++; $display("FAIL init_read0 actual=%b/%h required=0001/0", reg_rsp_vld, reg_rsp_data[0]);
    end
    reg_req[3] = '{vld: 1'b1, reg_id: 5'd31, addr: 16'h003F, data: 64'h0};
    #1;
    total++;
    if (reg_req_grant !== 4'b1000) begin bad++; $display("FAIL grant_lane3 actual=%b required=1000", reg_req_grant); end
    step();
    reg_req[3] = '0;
    total++;
    if (reg_rsp_vld !== 4'b1000 || reg_rsp_data[3] !== 64'h0) begin
      bad++; $display("FAIL init_read3 actual=%b/%h required=1000/0", reg_rsp_vld, reg_rsp_data[3]);
    end
  endtask

  task automatic test_write_read();
    wb_reg_req[0] = '{vld: 1'b1, reg_id: 5'd5, addr: 16'h0143, data: 64'hDEAD_BEEF};
    #1;
    total++;
    if (wb_reg_req_grant !== 2'b01) begin bad++; $display("FAIL wr_grant actual=%b required=01", wb_reg_req_grant); end
    step();
    wb_reg_req[0] = '0;
    total++;
    if (wb_reg_rsp_vld !== 2'b01 || wb_reg_rsp_data[0] !== 64'hDEAD_BEEF) begin
      bad++; $display("FAIL wr_ack actual=%b/%h required=01/deadbeef", wb_reg_rsp_vld, wb_reg_rsp_data[0]);
    end
    step();
    total++;
    if (wb_reg_rsp_vld !== 2'b00) begin bad++; $display("FAIL wr_ack_single actual=%b required=00", wb_reg_rsp_vld); end
    reg_req[2] = '{vld: 1'b1, reg_id: 5'd5, addr: 16'h0003, data: 64'h0};
    #1;
    total++;
    if (reg_req_grant !== 4'b0100) begin bad++; $display("FAIL rd2_grant actual=%b required=0100", reg_req_grant); end
    step();
    reg_req[2] = '0;
    total++;
    if (reg_rsp_vld !== 4'b0100 || reg_rsp_data[2] !== 64'hDEAD_BEEF) begin
      bad++; $display("FAIL rd2_data actual=%b/%h required=0100/deadbeef", reg_rsp_vld, reg_rsp_data[2]);
    end
  endtask

  task automatic test_round_robin();
    int last [NUM_OF_LANES];
    int max_wait;
    clear_reqs();
    do_reset_and_check("rr");
    for (int k = 0; k < 4; k++) begin
      wb_reg_req[0] = '{vld: 1'b1, reg_id: 5'(k + 1), addr: 16'(k), data: 64'hA0 + 64'(k)};
      #1;
      total++;
      if (wb_reg_req_grant !== 2'b01) begin bad++; $display("FAIL rr_fill_grant k=%0d actual=%b required=01", k, wb_reg_req_grant); end
      step();
    end
    wb_reg_req[0] = '0;
    for (int i = 0; i < NUM_OF_LANES; i++) begin
      reg_req[i] = '{vld: 1'b1, reg_id: 5'(i + 1), addr: 16'(i), data: 64'h0};
      last[i] = -1;
    end
    max_wait = 0;
    for (int c = 0; c < 8; c++) begin
      int e;
      e = c % 4;
      #1;
      total++;
      if (reg_req_grant !== 4'(1 << e)) begin bad++; $display("FAIL rr_grant c=%0d actual=%b required=%b", c, reg_req_grant, 4'(1 << e)); end
      if (c - last[e] - 1 > max_wait) max_wait = c - last[e] - 1;
      last[e] = c;
      step();
      total++;
      if (reg_rsp_vld !== 4'(1 << e) || reg_rsp_data[e] !== 64'hA0 + 64'(e)) begin
        bad++; $display("FAIL rr_rsp c=%0d actual=%b/%h required=%b/%h", c, reg_rsp_vld, reg_rsp_data[e], 4'(1 << e), 64'hA0 + 64'(e));
      end
    end
    total++;
    if (max_wait > 3) begin bad++; $display("FAIL rr_max_wait actual=%0d required<=3", max_wait); end
    clear_reqs();
    step();
    total++;
    if (reg_rsp_vld !== 4'b0000) begin bad++; $display("FAIL rr_drain actual=%b required=0000", reg_rsp_vld); end
  endtask

  task automatic test_collision();
    wb_reg_req[1] = '{vld: 1'b1, reg_id: 5'd7, addr: 16'h0000, data: 64'h1};
    reg_req[1]    = '{vld: 1'b1, reg_id: 5'd7, addr: 16'h0000, data: 64'h0};
    #1;
    total++;
    if (wb_reg_req_grant !== 2'b10 || reg_req_grant !== 4'b0010) begin
      bad++; $display("FAIL col_grants actual=%b/%b required=10/0010", wb_reg_req_grant, reg_req_grant);
    end
    step();
    wb_reg_req[1] = '0;
    total++;
    if (reg_rsp_vld !== 4'b0010 || reg_rsp_data[1] !== COLLIDE_EXP) begin
      bad++; $display("FAIL col_same_cycle actual=%b/%h required=0010/%h", reg_rsp_vld, reg_rsp_data[1], COLLIDE_EXP);
    end
    #1;
    total++;
    if (reg_req_grant !== 4'b0010) begin bad++; $display("FAIL col_b2b_grant actual=%b required=0010", reg_req_grant); end
    step();
    reg_req[1] = '0;
    total++;
    if (reg_rsp_vld !== 4'b0010 || reg_rsp_data[1] !== 64'h1) begin
      bad++; $display("FAIL col_after actual=%b/%h required=0010/1", reg_rsp_vld, reg_rsp_data[1]);
    end
  endtask

  task automatic test_wb_alternate();
    int cnt [NUM_OF_WB];
    logic [63:0] exp_data;
    cnt[0] = 0;
    cnt[1] = 0;
    for (int c = 0; c < 4; c++) begin
      int g;
      g = c % 2;
      for (int j = 0; j < NUM_OF_WB; j++)
        wb_reg_req[j] = '{vld: 1'b1, reg_id: 5'(20 + j), addr: 16'(cnt[j]), data: 64'hB000 + 64'(j * 16 + cnt[j])};
      #1;
      total++;
      if (wb_reg_req_grant !== 2'(1 << g)) begin bad++; $display("FAIL wb_alt_grant c=%0d actual=%b required=%b", c, wb_reg_req_grant, 2'(1 << g)); end
      exp_data = 64'hB000 + 64'(g * 16 + cnt[g]);
      step();
      total++;
      if (wb_reg_rsp_vld !== 2'(1 << g) || wb_reg_rsp_data[g] !== exp_data) begin
        bad++; $display("FAIL wb_alt_ack c=%0d actual=%b/%h required=%b/%h", c, wb_reg_rsp_vld, wb_reg_rsp_data[g], 2'(1 << g), exp_data);
      end
      cnt[g]++;
    end
    clear_reqs();
    step();
    total++;
    if (wb_reg_rsp_vld !== 2'b00) begin bad++; $display("FAIL wb_alt_drain actual=%b required=00", wb_reg_rsp_vld); end
    reg_req[0] = '{vld: 1'b1, reg_id: 5'd21, addr: 16'h0001, data: 64'h0};
    step();
    reg_req[0] = '0;
    total++;
    if (reg_rsp_vld !== 4'b0001 || reg_rsp_data[0] !== 64'hB011) begin
      bad++; $display("FAIL wb_alt_readback actual=%b/%h required=0001/b011", reg_rsp_vld, reg_rsp_data[0]);
    end
  endtask

  task automatic test_reset_midflight();
    wb_reg_req[0] = '{vld: 1'b1, reg_id: 5'd9, addr: 16'h0009, data: 64'h1234};
    step();
    wb_reg_req[0] = '0;
    reg_req[0] = '{vld: 1'b1, reg_id: 5'd9, addr: 16'h0009, data: 64'h0};
    #1;
    total++;
    if (reg_req_grant !== 4'b0001) begin bad++; $display("FAIL mid_grant actual=%b required=0001", reg_req_grant); end
    reset = 1'b1;
    step();
    total++;
    if (reg_rsp_vld !== 4'b0000 || init_done !== 1'b0) begin
      bad++; $display("FAIL mid_drop actual=%b/%b required=0000/0", reg_rsp_vld, init_done);
    end
    reset = 1'b0;
    begin
      int cyc, seen;
      wait_init(cyc, seen);
      total++;
      if (cyc !== 32) begin bad++; $display("FAIL mid_init_cycles actual=%0d required=32", cyc); end
      total++;
      if (seen !== 0) begin bad++; $display("FAIL mid_grant_in_init actual=%0d required=0", seen); end
    end
    step();
    reg_req[0] = '0;
    total++;
    if (reg_rsp_vld !== 4'b0001 || reg_rsp_data[0] !== 64'h0) begin
      bad++; $display("FAIL mid_readback actual=%b/%h required=0001/0", reg_rsp_vld, reg_rsp_data[0]);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_collision();
    test_wb_alternate();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
